// File: rtl/rf_plus_alu_pkg.sv
// Shared sizing and ALU operation encoding for the register-file-plus-ALU block.
// Imported by both the register file and the top level.
package rf_plus_alu_pkg;

  localparam int DATA_W  = 16;
  localparam int REG_NUM = 8;
  localparam int ADDR_W  = 3;
  localparam int IMM_W   = 5;

  typedef enum logic [1:0] {
    OP_ADD,
    OP_ADC,
    OP_SUB,
    OP_SBB
  } alu_op_e;

  // SBB outranks SUB, which outranks ADC; no select means ADD.
  function automatic alu_op_e decode_op(input logic adc, input logic sub, input logic sbb);
    if (sbb)      return OP_SBB;
    else if (sub) return OP_SUB;
    else if (adc) return OP_ADC;
    else          return OP_ADD;
  endfunction

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/rf_regfile.sv
// 8 x 16-bit register file: one synchronous write port, two combinational read ports.
// Reads do not bypass a same-cycle write; new data appears after the clock edge.
module rf_regfile
  import rf_plus_alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] r_regs [REG_NUM];

  // NOTE: the whole array is reset because every register must read zero
  // after reset; this forces flops rather than a RAM macro, which is fine at 8 entries.
  // Non-blocking assignments keep the write ordered against the combinational reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) r_regs[i] <= '0;
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_regs[i_raddr_a];
  assign o_rdata_b = r_regs[i_raddr_b];

endmodule

// File: rtl/rf_plus_alu.sv
// Register file feeding a 16-bit add/subtract ALU with carry-in and Z/N/C/V flags.
// The ALU result and flags are purely combinational; nothing beyond the registers is stored.
module rf_plus_alu
  import rf_plus_alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Read_Addr_A,
  input  logic [ADDR_W-1:0] Read_Addr_B,
  input  logic [DATA_W-1:0] Write_Data,
  input  logic [ADDR_W-1:0] Write_Addr,
  input  logic              Write_En,
  input  logic              Pre_C,
  input  logic              Src_ALU_B,
  input  logic [IMM_W-1:0]  imm5,
  input  logic              ADC,
  input  logic              SUB,
  input  logic              SBB,
  output logic [DATA_W-1:0] OutA,
  output logic [DATA_W-1:0] OutB,
  output logic [DATA_W-1:0] Y,
  output logic              Z,
  output logic              N,
  output logic              C,
  output logic              V
);

  alu_op_e           w_op;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_b_eff;
  logic              w_cin;
  logic [DATA_W:0]   w_sum;

  rf_regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (Write_En),
    .i_waddr   (Write_Addr),
    .i_wdata   (Write_Data),
    .i_raddr_a (Read_Addr_A),
    .i_raddr_b (Read_Addr_B),
    .o_rdata_a (OutA),
    .o_rdata_b (OutB)
  );

  assign w_op = decode_op(ADC, SUB, SBB);
  assign w_b  = Src_ALU_B ? sext_imm(imm5) : OutB;

  // NOTE: defaults first so every path assigns both signals and no latch is inferred.
  always_comb begin
    w_b_eff = w_b;
    w_cin   = 1'b0;
    case (w_op)
      OP_ADD: ;
      OP_ADC: w_cin = Pre_C;
      OP_SUB: begin
        w_b_eff = ~w_b;
        w_cin   = 1'b1;
      end
      OP_SBB: begin
        w_b_eff = ~w_b;
        w_cin   = Pre_C;
      end
      default: ;
    endcase
  end

  // One 17-bit adder serves all four operations; bit 16 is the carry (no-borrow for subtracts).
  assign w_sum = {1'b0, OutA} + {1'b0, w_b_eff} + {{DATA_W{1'b0}}, w_cin};

  assign Y = w_sum[DATA_W-1:0];
  assign C = w_sum[DATA_W];
  assign Z = (Y == '0);
  assign N = Y[DATA_W-1];
  assign V = (OutA[DATA_W-1] == w_b_eff[DATA_W-1]) && (Y[DATA_W-1] != OutA[DATA_W-1]);

endmodule

// File: tb/tb_rf_plus_alu.sv
// Self-checking bench for rf_plus_alu: directed literal checks plus randomized
// traffic compared every cycle against an arithmetic reference model.
module tb_rf_plus_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  Read_Addr_A = '0, Read_Addr_B = '0, Write_Addr = '0;
  logic [15:0] Write_Data = '0;
  logic        Write_En = 1'b0, Pre_C = 1'b0, Src_ALU_B = 1'b0;
  logic [4:0]  imm5 = '0;
  logic        ADC = 1'b0, SUB = 1'b0, SBB = 1'b0;
  logic [15:0] OutA, OutB, Y;
  logic        Z, N, C, V;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [15:0] model_regs [8];

  rf_plus_alu dut (
    .clk(clk), .rst_n(rst_n),
    .Read_Addr_A(Read_Addr_A), .Read_Addr_B(Read_Addr_B),
    .Write_Data(Write_Data), .Write_Addr(Write_Addr), .Write_En(Write_En),
    .Pre_C(Pre_C), .Src_ALU_B(Src_ALU_B), .imm5(imm5),
    .ADC(ADC), .SUB(SUB), .SBB(SBB),
    .OutA(OutA), .OutB(OutB), .Y(Y), .Z(Z), .N(N), .C(C), .V(V)
  );

  always #10 clk = ~clk;

  initial for (int i = 0; i < 8; i++) model_regs[i] = '0;

  always @(negedge rst_n) for (int i = 0; i < 8; i++) model_regs[i] = '0;

  always @(posedge clk) if (rst_n && Write_En) model_regs[Write_Addr] = Write_Data;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference ALU in plain integer arithmetic: subtracts are real subtractions,
  // carry/overflow come from the range of the unsigned/signed results.
  function automatic void model_alu(input logic [15:0] a, input logic [15:0] b,
                                    input bit pc, input bit adc, input bit sub, input bit sbb,
                                    output logic [15:0] y, output bit z, output bit n,
                                    output bit c, output bit v);
    int ua, ub, sa, sb, r, sr, k;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sbb || sub) begin
      k  = sbb ? (pc ? 0 : 1) : 0;
      r  = ua - ub - k;
      sr = sa - sb - k;
      c  = (r >= 0);
    end else begin
      k  = adc ? int'(pc) : 0;
      r  = ua + ub + k;
      sr = sa + sb + k;
      c  = (r > 65535);
    end
    y = r[15:0];
    z = (y == 16'h0000);
    n = y[15];
    v = (sr > 32767) || (sr < -32768);
  endfunction

  task automatic compare_all(input string tag);
    logic [15:0] ea, eb, bop, ey;
    bit ez, en, ec, ev;
    ea  = model_regs[Read_Addr_A];
    eb  = model_regs[Read_Addr_B];
    bop = Src_ALU_B ? 16'($signed(imm5)) : eb;
    model_alu(ea, bop, Pre_C, ADC, SUB, SBB, ey, ez, en, ec, ev);
    check({tag, ".OutA"}, OutA, ea);
    check({tag, ".OutB"}, OutB, eb);
    check({tag, ".Y"}, Y, ey);
    check({tag, ".Z"}, {15'd0, Z}, {15'd0, ez});
    check({tag, ".N"}, {15'd0, N}, {15'd0, en});
    check({tag, ".C"}, {15'd0, C}, {15'd0, ec});
    check({tag, ".V"}, {15'd0, V}, {15'd0, ev});
  endtask

  always @(negedge clk) if (cmp_en) compare_all("cyc");

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
    step();
    Write_En   = 1'b1;
    Write_Addr = a;
    Write_Data = d;
  endtask

  task automatic set_alu(input logic [2:0] ra, input logic [2:0] rb, input bit src,
                         input logic [4:0] imm, input bit adc, input bit sub,
                         input bit sbb, input bit pc);
    step();
    Write_En    = 1'b0;
    Read_Addr_A = ra;
    Read_Addr_B = rb;
    Src_ALU_B   = src;
    imm5        = imm;
    ADC = adc; SUB = sub; SBB = sbb; Pre_C = pc;
    #1;
  endtask

  task automatic check_flags(input string name, input logic [15:0] ey,
                             input bit ez, input bit en, input bit ec, input bit ev);
    check({name, ".Y"}, Y, ey);
    check({name, ".ZNCV"}, {12'd0, Z, N, C, V}, {12'd0, ez, en, ec, ev});
  endtask

  initial begin
    logic [15:0] corner [4];
    corner[0] = 16'h0000; corner[1] = 16'h7FFF; corner[2] = 16'h8000; corner[3] = 16'hFFFF;

    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.OutA", OutA, 16'h0000);
    rst_n = 1'b1;
    #1;
    check("post_rst.OutB", OutB, 16'h0000);
    check_flags("post_rst", 16'h0000, 1, 0, 0, 0);

    // Literal pins for the model and the datapath.
    write_reg(3'd0, 16'h1234);
    write_reg(3'd1, 16'h2345);
    write_reg(3'd2, 16'h7FFF);
    set_alu(0, 1, 0, 0, 0, 0, 0, 0); check_flags("add", 16'h3579, 0, 0, 0, 0);
    set_alu(0, 1, 0, 0, 1, 0, 0, 0); check_flags("adc0", 16'h3579, 0, 0, 0, 0);
    set_alu(0, 1, 0, 0, 1, 0, 0, 1); check_flags("adc1", 16'h357A, 0, 0, 0, 0);
    set_alu(0, 1, 0, 0, 0, 1, 0, 0); check_flags("sub0", 16'hEEEF, 0, 1, 0, 0);
    set_alu(0, 1, 0, 0, 0, 1, 0, 1); check_flags("sub1", 16'hEEEF, 0, 1, 0, 0);
    set_alu(0, 1, 0, 0, 0, 0, 1, 0); check_flags("sbb0", 16'hEEEE, 0, 1, 0, 0);
    set_alu(0, 1, 0, 0, 0, 0, 1, 1); check_flags("sbb1", 16'hEEEF, 0, 1, 0, 0);
    set_alu(0, 1, 0, 0, 1, 1, 1, 0); check_flags("prio_sbb", 16'hEEEE, 0, 1, 0, 0);
    set_alu(0, 1, 0, 0, 1, 1, 0, 1); check_flags("prio_sub", 16'hEEEF, 0, 1, 0, 0);
    set_alu(0, 1, 1, 5'h1F, 0, 0, 0, 0); check_flags("imm_m1", 16'h1233, 0, 0, 1, 0);
    set_alu(2, 1, 1, 5'h01, 0, 0, 0, 0); check_flags("ovf", 16'h8000, 0, 1, 0, 1);
    set_alu(0, 0, 0, 0, 0, 1, 0, 0); check_flags("sub_self", 16'h0000, 1, 0, 1, 0);

    // Disabled write leaves R0 intact; same-cycle write is not bypassed.
    step();
    Write_En = 1'b0; Write_Addr = 3'd0; Write_Data = 16'hFFFF; Read_Addr_A = 3'd0;
    step();
    check("we0_hold", OutA, 16'h1234);
    Write_En = 1'b1; Write_Addr = 3'd3; Write_Data = 16'hABCD; Read_Addr_A = 3'd3;
    #1;
    check("no_bypass", OutA, 16'h0000);
    step();
    Write_En = 1'b0;
    #1;
    check("after_edge", OutA, 16'hABCD);

    // Randomized traffic; the negedge compare process checks every cycle.
    for (int it = 0; it < 400; it++) begin
      step();
      Write_En    = ($urandom_range(0, 2) != 0);
      Write_Addr  = 3'($urandom_range(0, 7));
      Write_Data  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
      Read_Addr_A = 3'($urandom_range(0, 7));
      Read_Addr_B = 3'($urandom_range(0, 7));
      Src_ALU_B   = ($urandom_range(0, 3) == 0);
      imm5        = 5'($urandom);
      Pre_C       = 1'($urandom);
      ADC         = 1'($urandom);
      SUB         = ($urandom_range(0, 2) == 0);
      SBB         = ($urandom_range(0, 2) == 0);
    end

    // Reset asserted between clock edges clears all registers immediately.
    step();
    Write_En = 1'b0;
    for (int i = 0; i < 8; i++) begin
      Write_Addr = 3'(i);
      Write_Data = 16'h1111 * 16'(i + 1);
      Write_En   = 1'b1;
      step();
    end
    Write_En = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      Read_Addr_A = 3'(i);
      Read_Addr_B = 3'(i + 4);
      #1;
      check("midrst.OutA", OutA, 16'h0000);
      check("midrst.OutB", OutB, 16'h0000);
    end
    step();
    Write_En = 1'b1; Write_Addr = 3'd2; Write_Data = 16'h5555; Read_Addr_A = 3'd2;
    step();
    check("rst_blocks_write", OutA, 16'h0000);
    Write_En = 1'b0;
    rst_n = 1'b1;
    set_alu(5, 6, 0, 0, 0, 0, 0, 0); check_flags("post_midrst", 16'h0000, 1, 0, 0, 0);

    step();
    step();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
